// File: rtl/seq_det_pkg.sv
// Shared constants and elaboration-time helpers for the parametrised Moore sequence detector.
// Prefix bit j of a pattern is the j-th bit received, i.e. pattern[len-1-j].
package seq_det_pkg;

    localparam int unsigned S0 = 0;

    function automatic int unsigned clog2(input int unsigned val);
        int unsigned r;
        r = 0;
        for (int unsigned i = 0; i < 32; i++) begin
            if ((64'd1 << i) < 64'(val)) r = i + 1;
        end
        return r;
    endfunction

    function automatic logic pat_bit(input logic [15:0] pattern, input int unsigned len,
                                     input int unsigned j);
        return pattern[4'(len - 1 - j)];
    endfunction

    // Longest proper prefix of the first k pattern bits that is also their suffix.
    function automatic int unsigned fail_len(input logic [15:0] pattern, input int unsigned len,
                                             input int unsigned k);
        int unsigned best;
        logic        ok;
        best = 0;
        for (int unsigned l = 1; l < k; l++) begin
            ok = 1'b1;
            for (int unsigned j = 0; j < l; j++) begin
                if (pat_bit(pattern, len, j) != pat_bit(pattern, len, k - l + j)) ok = 1'b0;
            end
            if (ok) best = l;
        end
        return best;
    endfunction

    // Apply bit d from prefix state k (k < len), walking the failure chain on mismatch.
    function automatic int unsigned kmp_step(input logic [15:0] pattern, input int unsigned len,
                                             input int unsigned k, input logic d);
        int unsigned j;
        logic        done;
        j    = k;
        done = 1'b0;
        for (int i = 0; i < 17; i++) begin
            if (!done) begin
                if (pat_bit(pattern, len, j) == d) begin
                    j    = j + 1;
                    done = 1'b1;
                end else if (j == 0) begin
                    done = 1'b1;
                end else begin
                    j = fail_len(pattern, len, j);
                end
            end
        end
        return j;
    endfunction

endpackage

// File: rtl/seq_det_next_state.sv
// Combinational next-state lookup; the transition table is computed from PATTERN at elaboration.
module seq_det_next_state
    import seq_det_pkg::*;
#(
    parameter int unsigned          PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0]   PATTERN = 3'b110,
    parameter int unsigned          SW      = 2
) (
    input  logic [SW-1:0] i_state,
    input  logic          i_d,
    input  logic          i_overlap,
    output logic [SW-1:0] o_nextstate,
    output logic          o_valid
);

    localparam logic [15:0] PAT_EXT = 16'(PATTERN);

    function automatic int unsigned next_of(input int unsigned k, input logic d, input logic ov);
        int unsigned j;
        if (k >= PAT_LEN) j = ov ? fail_len(PAT_EXT, PAT_LEN, PAT_LEN) : 0;
        else              j = k;
        return kmp_step(PAT_EXT, PAT_LEN, j, d);
    endfunction

    logic [SW-1:0] w_tbl [PAT_LEN+1][2][2];

    for (genvar k = 0; k <= PAT_LEN; k++) begin : g_row
        for (genvar b = 0; b < 2; b++) begin : g_bit
            for (genvar o = 0; o < 2; o++) begin : g_ovl
                localparam int unsigned NXT = next_of(k, 1'(b), 1'(o));
                assign w_tbl[k][b][o] = SW'(NXT);
            end
        end
    end

    // Encodings above PAT_LEN match no row and fall back to S0.
    always_comb begin
        o_nextstate = SW'(S0);
        o_valid     = 1'b0;
        for (int unsigned k = 0; k <= PAT_LEN; k++) begin
            if (i_state == SW'(k)) begin
                o_nextstate = w_tbl[k][i_d][i_overlap];
                o_valid     = 1'b1;
            end
        end
    end

endmodule

// File: rtl/seq_detector_moore_param.sv
// Parametrised Moore serial pattern detector with enable, sync clear and saturating hit counter.
// Define SEQ_DET_STATE_TXT_EN to get an ASCII state name (txstate) for waveform debug.
module seq_detector_moore_param
    import seq_det_pkg::*;
#(
    parameter int unsigned        PAT_LEN = 3,
    parameter logic [PAT_LEN-1:0] PATTERN = 3'b110,
    parameter int unsigned        CNT_W   = 8
) (
    input  logic             clk,
    input  logic             _rst,
    input  logic             clr,
    input  logic             en,
    input  logic             D,
    input  logic             overlap,
    output logic             Q,
    output logic [CNT_W-1:0] match_cnt
);

    if (PAT_LEN < 2 || PAT_LEN > 16) begin : g_bad_len
        $error("seq_detector_moore_param: PAT_LEN must be in 2..16");
    end
    if (CNT_W < 1 || CNT_W > 32) begin : g_bad_cnt
        $error("seq_detector_moore_param: CNT_W must be in 1..32");
    end

    localparam int unsigned   SW    = clog2(PAT_LEN + 1);
    localparam logic [SW-1:0] ST_S0 = SW'(S0);
    localparam logic [SW-1:0] HIT   = SW'(PAT_LEN);

    logic [SW-1:0]    r_state;
    logic             r_q;
    logic [CNT_W-1:0] r_cnt;

    logic [SW-1:0]    w_nextstate;
    logic             w_valid;
    logic [SW-1:0]    w_state_d;
    logic             w_q_d;
    logic [CNT_W-1:0] w_cnt_d;
    logic             w_q_ns;

    seq_det_next_state #(
        .PAT_LEN (PAT_LEN),
        .PATTERN (PATTERN),
        .SW      (SW)
    ) u_next_state (
        .i_state     (r_state),
        .i_d         (D),
        .i_overlap   (overlap),
        .o_nextstate (w_nextstate),
        .o_valid     (w_valid)
    );

    assign w_q_ns = (r_state == HIT);

    always_comb begin
        w_state_d = r_state;
        w_q_d     = 1'b0;
        w_cnt_d   = r_cnt;
        if (clr) begin
            w_state_d = ST_S0;
            w_cnt_d   = '0;
        end else if (!w_valid) begin
            w_state_d = ST_S0;
        end else if (en) begin
            w_state_d = w_nextstate;
            w_q_d     = w_q_ns;
            // Count on entry into HIT only; saturate at all-ones.
            if (w_nextstate == HIT && !(&r_cnt)) w_cnt_d = r_cnt + CNT_W'(1);
        end
    end

    always_ff @(posedge clk or negedge _rst) begin
        if (!_rst) begin
            r_state <= ST_S0;
            r_q     <= 1'b0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_d;
            r_q     <= w_q_d;
            r_cnt   <= w_cnt_d;
        end
    end

    assign Q         = r_q;
    assign match_cnt = r_cnt;

`ifdef SEQ_DET_STATE_TXT_EN
    reg [63:0]   txstate;
    int unsigned w_st_num;
    assign w_st_num = 32'(r_state);
    always_comb begin
        if (r_state == HIT)     txstate = 64'("HIT");
        else if (w_st_num < 10) txstate = {48'd0, "S", 8'(48 + w_st_num)};
        else                    txstate = {40'd0, "S1", 8'(38 + w_st_num)};
    end
`endif

endmodule
